// File: rtl/csr_access_sequencer.sv
// Single owner of the machine-mode CSR file port: sequences trap entry, mret
// and Zicsr instruction accesses as fixed read/write series.
module csr_access_sequencer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        trap_req_i,
   input  logic [31:0] trap_cause_i,
   input  logic [31:0] trap_pc_i,
   input  logic        mret_req_i,
   input  logic        instr_req_i,
   input  logic [1:0]  instr_op_i,
   input  logic [11:0] instr_addr_i,
   input  logic [31:0] instr_wdata_i,
   output logic        instr_ack_o,
   output logic [31:0] instr_rdata_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        busy_o,
   output logic        csr_write_enable_o,
   output logic        csr_read_enable_o,
   output logic [11:0] csr_address_o,
   output logic [31:0] csr_write_data_o,
   input  logic [31:0] csr_read_data_i,
   output logic [3:0]  state_o
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_TR_VEC   = 4'd1,
      S_TR_ST    = 4'd2,
      S_TW_EPC   = 4'd3,
      S_TW_CAUSE = 4'd4,
      S_TW_ST    = 4'd5,
      S_MR_EPC   = 4'd6,
      S_MR_ST    = 4'd7,
      S_MW_ST    = 4'd8,
      S_DONE     = 4'd9,
      S_IR_RD    = 4'd10,
      S_IW_WR    = 4'd11
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cause_q, pc_q, wdata_q, vec_q, st_q;
   logic [29:0] epc_q;
   logic [11:0] addr_q;
   logic [1:0]  op_q;
   logic        is_trap_q;

   logic [31:0] trap_st, mret_st, instr_new, vec_base, trap_target;
   logic        instr_we;

   assign state_o = state_q;

   // Handshake: a requester holds its level request until its completion pulse
   // (redirect_valid_o or instr_ack_o) and drops it at the next edge; requests
   // are only sampled in IDLE, so held requests wait rather than get lost.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cause_q   <= '0;
         pc_q      <= '0;
         wdata_q   <= '0;
         addr_q    <= '0;
         op_q      <= '0;
         is_trap_q <= 1'b0;
         vec_q     <= '0;
         st_q      <= '0;
         epc_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (trap_req_i || mret_req_i || instr_req_i) begin
                  cause_q   <= trap_cause_i;
                  pc_q      <= trap_pc_i;
                  wdata_q   <= instr_wdata_i;
                  addr_q    <= instr_addr_i;
                  op_q      <= instr_op_i;
                  is_trap_q <= trap_req_i;
               end
            end
            S_TR_ST:  vec_q <= csr_read_data_i;
            S_TW_EPC: st_q  <= csr_read_data_i;
            S_MR_ST:  epc_q <= csr_read_data_i[31:2];
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (trap_req_i)       state_d = S_TR_VEC;
            else if (mret_req_i)  state_d = S_MR_EPC;
            else if (instr_req_i) state_d = S_IR_RD;
         end
         S_TR_VEC:   state_d = S_TR_ST;
         S_TR_ST:    state_d = S_TW_EPC;
         S_TW_EPC:   state_d = S_TW_CAUSE;
         S_TW_CAUSE: state_d = S_TW_ST;
         S_TW_ST:    state_d = S_DONE;
         S_MR_EPC:   state_d = S_MR_ST;
         S_MR_ST:    state_d = S_MW_ST;
         S_MW_ST:    state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         S_IR_RD:    state_d = S_IW_WR;
         S_IW_WR:    state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // mstatus updates: trap stacks MIE into MPIE; mret restores MIE from MPIE.
   assign trap_st = {st_q[31:13], 2'b11, st_q[10:8], st_q[3], st_q[6:4], 1'b0, st_q[2:0]};
   assign mret_st = {csr_read_data_i[31:13], 2'b11, csr_read_data_i[10:8], 1'b1,
                     csr_read_data_i[6:4], csr_read_data_i[7], csr_read_data_i[2:0]};

   assign vec_base    = {vec_q[31:2], 2'b00};
   assign trap_target = (vec_q[1:0] == 2'b01 && cause_q[31])
                        ? vec_base + {cause_q[29:0], 2'b00} : vec_base;

   assign instr_we = (op_q == 2'b01) || (op_q[1] && (wdata_q != 32'd0));

   always_comb begin
      case (op_q)
         2'b01:   instr_new = wdata_q;
         2'b10:   instr_new = csr_read_data_i | wdata_q;
         2'b11:   instr_new = csr_read_data_i & ~wdata_q;
         default: instr_new = csr_read_data_i;
      endcase
   end

   always_comb begin
      csr_write_enable_o = 1'b0;
      csr_read_enable_o  = 1'b0;
      csr_address_o      = '0;
      csr_write_data_o   = '0;
      instr_ack_o        = 1'b0;
      instr_rdata_o      = '0;
      redirect_valid_o   = 1'b0;
      redirect_pc_o      = '0;
      busy_o             = (state_q != S_IDLE);
      case (state_q)
         S_TR_VEC: begin
            csr_read_enable_o = 1'b1;
            csr_address_o     = A_MTVEC;
         end
         S_TR_ST, S_MR_ST: begin
            csr_read_enable_o = 1'b1;
            csr_address_o     = A_MSTATUS;
         end
         S_TW_EPC: begin
            csr_write_enable_o = 1'b1;
            csr_address_o      = A_MEPC;
            csr_write_data_o   = pc_q;
         end
         S_TW_CAUSE: begin
            csr_write_enable_o = 1'b1;
            csr_address_o      = A_MCAUSE;
            csr_write_data_o   = cause_q;
         end
         S_TW_ST: begin
            csr_write_enable_o = 1'b1;
            csr_address_o      = A_MSTATUS;
            csr_write_data_o   = trap_st;
         end
         S_MR_EPC: begin
            csr_read_enable_o = 1'b1;
            csr_address_o     = A_MEPC;
         end
         S_MW_ST: begin
            csr_write_enable_o = 1'b1;
            csr_address_o      = A_MSTATUS;
            csr_write_data_o   = mret_st;
         end
         S_DONE: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = is_trap_q ? trap_target : {epc_q, 2'b00};
         end
         S_IR_RD: begin
            csr_read_enable_o = 1'b1;
            csr_address_o     = addr_q;
         end
         S_IW_WR: begin
            instr_ack_o        = 1'b1;
            instr_rdata_o      = csr_read_data_i;
            csr_address_o      = addr_q;
            csr_write_enable_o = instr_we;
            csr_write_data_o   = instr_we ? instr_new : 32'd0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Randomized bench for csr_access_sequencer with a CSR file model and an
// abstract reference model of the architectural CSR effects.
module tb_csr_access_sequencer;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        trap_req_i = 1'b0;
   logic [31:0] trap_cause_i = '0;
   logic [31:0] trap_pc_i = '0;
   logic        mret_req_i = 1'b0;
   logic        instr_req_i = 1'b0;
   logic [1:0]  instr_op_i = '0;
   logic [11:0] instr_addr_i = '0;
   logic [31:0] instr_wdata_i = '0;
   logic        instr_ack_o, redirect_valid_o, busy_o;
   logic [31:0] instr_rdata_o, redirect_pc_o;
   logic        csr_write_enable_o, csr_read_enable_o;
   logic [11:0] csr_address_o;
   logic [31:0] csr_write_data_o;
   logic [31:0] csr_read_data_i;
   logic [3:0]  state_o;

   always #5 clk = ~clk;

   csr_access_sequencer dut (
      .clk_i(clk), .rst_i(rst_i),
      .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
      .mret_req_i(mret_req_i),
      .instr_req_i(instr_req_i), .instr_op_i(instr_op_i), .instr_addr_i(instr_addr_i),
      .instr_wdata_i(instr_wdata_i), .instr_ack_o(instr_ack_o), .instr_rdata_o(instr_rdata_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o),
      .csr_write_enable_o(csr_write_enable_o), .csr_read_enable_o(csr_read_enable_o),
      .csr_address_o(csr_address_o), .csr_write_data_o(csr_write_data_o),
      .csr_read_data_i(csr_read_data_i), .state_o(state_o)
   );

   // CSR file model: registered read data, plus a preload path for setup.
   logic [31:0] csr_mem [0:4095];
   logic [31:0] rd_q = '0;
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [31:0] pl_data = '0;
   assign csr_read_data_i = rd_q;

   always @(posedge clk) begin
      if (pl_en) csr_mem[pl_addr] <= pl_data;
      else if (csr_write_enable_o) csr_mem[csr_address_o] <= csr_write_data_o;
      if (csr_read_enable_o) rd_q <= csr_mem[csr_address_o];
   end

   int redir_cnt = 0, ack_cnt = 0, wr_cnt = 0, overlap_cnt = 0;
   always @(negedge clk) begin
      if (redirect_valid_o) redir_cnt++;
      if (instr_ack_o) ack_cnt++;
      if (csr_write_enable_o) wr_cnt++;
      if (redirect_valid_o && instr_ack_o) overlap_cnt++;
   end

   // Scoreboard state
   int          n_checks = 0, n_pass = 0;
   int          exp_redirs = 0, exp_acks = 0;
   logic [31:0] exp_q [$];
   logic [31:0] ref_csr [0:4095];
   logic [11:0] addr_list [6];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      ref_csr[a] = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Reference model: architectural effect of each request on the CSRs.
   task automatic model_trap(input logic [31:0] cause, input logic [31:0] pc);
      logic [31:0] vec, st, tgt;
      vec = ref_csr[12'h305];
      st  = ref_csr[12'h300];
      tgt = vec & 32'hFFFF_FFFC;
      if (vec[1:0] == 2'b01 && cause[31]) tgt = tgt + (cause & 32'h7FFF_FFFF) * 4;
      exp_q.push_back(tgt);
      ref_csr[12'h341] = pc;
      ref_csr[12'h342] = cause;
      ref_csr[12'h300] = (st & ~32'h0000_1888) | 32'h0000_1800 | (st[3] ? 32'h80 : 32'h0);
      exp_redirs++;
   endtask

   task automatic model_mret();
      logic [31:0] st;
      st = ref_csr[12'h300];
      exp_q.push_back(ref_csr[12'h341] & 32'hFFFF_FFFC);
      ref_csr[12'h300] = (st & ~32'h0000_1888) | 32'h0000_1880 | (st[7] ? 32'h8 : 32'h0);
      exp_redirs++;
   endtask

   task automatic model_instr(input logic [1:0] op, input logic [11:0] a,
                              input logic [31:0] wd, output int nwr);
      logic [31:0] old;
      old = ref_csr[a];
      exp_q.push_back(old);
      nwr = 0;
      if (op == 2'b01) begin
         ref_csr[a] = wd; nwr = 1;
      end else if (op != 2'b00 && wd != 0) begin
         ref_csr[a] = (op == 2'b10) ? (old | wd) : (old & ~wd);
         nwr = 1;
      end
      exp_acks++;
   endtask

   task automatic wait_done(input int sel, output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if ((sel == 0 && redirect_valid_o) || (sel == 1 && instr_ack_o)) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic check_trap_csrs();
      check("mem_mepc", csr_mem[12'h341], ref_csr[12'h341]);
      check("mem_mcause", csr_mem[12'h342], ref_csr[12'h342]);
      check("mem_mstatus", csr_mem[12'h300], ref_csr[12'h300]);
   endtask

   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc);
      int lat, w0;
      @(posedge clk); #1;
      check("idle_busy", busy_o, 0);
      model_trap(cause, pc);
      w0 = wr_cnt;
      trap_cause_i = cause; trap_pc_i = pc; trap_req_i = 1'b1;
      wait_done(0, lat);
      trap_req_i = 1'b0;
      check("trap_lat", lat, 6);
      check("trap_pc", redirect_pc_o, exp_q.pop_front());
      check("trap_busy", busy_o, 1);
      @(posedge clk); #1;
      check("trap_nwr", wr_cnt - w0, 3);
      check_trap_csrs();
      check("after_busy", busy_o, 0);
   endtask

   task automatic do_mret();
      int lat, w0;
      @(posedge clk); #1;
      check("idle_busy", busy_o, 0);
      model_mret();
      w0 = wr_cnt;
      mret_req_i = 1'b1;
      wait_done(0, lat);
      mret_req_i = 1'b0;
      check("mret_lat", lat, 4);
      check("mret_pc", redirect_pc_o, exp_q.pop_front());
      check("mret_busy", busy_o, 1);
      @(posedge clk); #1;
      check("mret_nwr", wr_cnt - w0, 1);
      check("mem_mstatus", csr_mem[12'h300], ref_csr[12'h300]);
   endtask

   task automatic do_instr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
      int lat, w0, nwr;
      @(posedge clk); #1;
      check("idle_busy", busy_o, 0);
      model_instr(op, a, wd, nwr);
      w0 = wr_cnt;
      instr_op_i = op; instr_addr_i = a; instr_wdata_i = wd; instr_req_i = 1'b1;
      wait_done(1, lat);
      instr_req_i = 1'b0;
      check("instr_lat", lat, 2);
      check("instr_rdata", instr_rdata_o, exp_q.pop_front());
      check("instr_busy", busy_o, 1);
      @(posedge clk); #1;
      check("instr_nwr", wr_cnt - w0, nwr);
      check("mem_instr", csr_mem[a], ref_csr[a]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, lat2, w0, nwr;
      logic [31:0] c, p, w;
      logic [1:0] op;
      addr_list[0] = 12'h300; addr_list[1] = 12'h305; addr_list[2] = 12'h340;
      addr_list[3] = 12'h341; addr_list[4] = 12'h342; addr_list[5] = 12'h7C0;
      for (int i = 0; i < 4096; i++) ref_csr[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_outs", {31'd0, |{instr_ack_o, instr_rdata_o, redirect_valid_o, redirect_pc_o,
                          busy_o, csr_write_enable_o, csr_read_enable_o, csr_address_o,
                          csr_write_data_o, state_o}}, 0);
      rst_i = 1'b0;
      for (int i = 0; i < 6; i++) preload(addr_list[i], 32'd0);

      // Vectored interrupt
      preload(12'h305, 32'h0000_1001);
      preload(12'h300, 32'h0000_0008);
      do_trap(32'h8000_0007, 32'h0000_0200);
      check("vec_mstatus_const", csr_mem[12'h300], 32'h0000_1880);

      // Mret
      preload(12'h341, 32'h0000_0203);
      preload(12'h300, 32'h0000_1880);
      do_mret();
      check("mret_mstatus_const", csr_mem[12'h300], 32'h0000_1888);

      // RS then RC-with-zero on mscratch
      preload(12'h340, 32'hF0F0_0000);
      do_instr(2'b10, 12'h340, 32'h0000_00FF);
      check("rs_new_const", csr_mem[12'h340], 32'hF0F0_00FF);
      do_instr(2'b11, 12'h340, 32'h0000_0000);

      // Non-vectored exception with wrap-capable base
      preload(12'h305, 32'hFFFF_FFFC);
      do_trap(32'h0000_0002, 32'h0000_0400);

      // Arbitration: trap and instr rise together
      preload(12'h305, 32'h0000_2001);
      @(posedge clk); #1;
      model_trap(32'h8000_0003, 32'h0000_0800);
      model_instr(2'b10, 12'h340, 32'h0000_0F00, nwr);
      trap_cause_i = 32'h8000_0003; trap_pc_i = 32'h0000_0800; trap_req_i = 1'b1;
      instr_op_i = 2'b10; instr_addr_i = 12'h340; instr_wdata_i = 32'h0000_0F00; instr_req_i = 1'b1;
      wait_done(0, lat);
      trap_req_i = 1'b0;
      check("arb_trap_lat", lat, 6);
      check("arb_trap_pc", redirect_pc_o, exp_q.pop_front());
      wait_done(1, lat2);
      instr_req_i = 1'b0;
      check("arb_ack_lat", lat + lat2, 9);
      check("arb_rdata", instr_rdata_o, exp_q.pop_front());
      @(posedge clk); #1;
      check_trap_csrs();
      check("arb_mscratch", csr_mem[12'h340], ref_csr[12'h340]);

      // Reset abort during TW_CAUSE
      @(posedge clk); #1;
      w0 = redir_cnt;
      trap_cause_i = 32'h0000_000B; trap_pc_i = 32'h0000_0C00; trap_req_i = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      rst_i = 1'b1; trap_req_i = 1'b0;
      ref_csr[12'h341] = 32'h0000_0C00;
      #1;
      check("abort_outs", {31'd0, |{instr_ack_o, instr_rdata_o, redirect_valid_o, redirect_pc_o,
                            busy_o, csr_write_enable_o, csr_read_enable_o, csr_address_o,
                            csr_write_data_o, state_o}}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_redirect", redir_cnt - w0, 0);
      check("abort_idle", busy_o, 0);
      check_trap_csrs();
      do_instr(2'b00, 12'h342, 32'h1234_5678);

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               if ($urandom_range(0, 1) == 1) preload(12'h305, $urandom);
               c = $urandom_range(0, 1) == 1 ? {1'b1, 31'($urandom_range(0, 15))} : $urandom;
               p = $urandom;
               do_trap(c, p);
            end
            1: do_mret();
            default: begin
               op = 2'($urandom_range(0, 3));
               w = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
               do_instr(op, addr_list[$urandom_range(0, 5)], w);
            end
         endcase
      end

      repeat (2) @(posedge clk);
      #1;
      check("exclusive_pulses", overlap_cnt, 0);
      check("redirect_total", redir_cnt, exp_redirs);
      check("ack_total", ack_cnt, exp_acks);
      check("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
